// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants for the SRAM port arbiter: default widths, idle write-enable
// pattern and the default fetch starvation limit.
package sram_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned STARVE_CNT_W   = 4;

  localparam logic [3:0] WEN_NONE = 4'b0000;

endpackage

// File: rtl/sram_port_arbiter_starve_counter.sv
// Saturating count of consecutive arbitrations lost by fetch to data. Raises
// force_inst once the limit is reached so fetch wins the next conflict.
module sram_port_arbiter_starve_counter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_req,
  input  logic                    data_req,
  output logic                    force_inst,
  output logic [STARVE_CNT_W-1:0] starve_cnt
);

  localparam logic [STARVE_CNT_W-1:0] Limit = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;
  logic                    at_limit;

  assign at_limit   = (cnt_q == Limit);
  assign force_inst = inst_req & data_req & at_limit;
  assign starve_cnt = cnt_q;

  // Fetch loses exactly when both request and it is not forced; any other case
  // means fetch either won or stopped asking, which clears the count.
  always_comb begin
    cnt_d = cnt_q;
    if (!inst_req || !data_req || force_inst) begin
      cnt_d = '0;
    end else if (!at_limit) begin
      cnt_d = cnt_q + STARVE_CNT_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port between instruction fetch and MEM-stage data
// accesses. Data has fixed priority, fetch is protected by a starvation guard,
// and each grant is tagged so its response returns to the owner a cycle later.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_gnt,
  input  logic              inst_cancel,
  output logic              inst_rvalid,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  logic                    force_inst;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    resp_inst_q, resp_inst_d;
  logic                    resp_data_q, resp_data_d;

  sram_port_arbiter_starve_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_counter (
    .clk       (clk),
    .rst       (rst),
    .inst_req  (inst_req),
    .data_req  (data_req),
    .force_inst(force_inst),
    .starve_cnt(starve_cnt)
  );

  // Combinational grant in the request cycle; the two are mutually exclusive.
  always_comb begin
    data_gnt = data_req & ~force_inst & ~rst;
    inst_gnt = inst_req & ~rst & (~data_req | force_inst);
  end

  // Route the granted requester onto the SRAM port; idle port is driven to 0.
  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = WEN_NONE;
    sram_addr  = '0;
    sram_wdata = '0;
    if (data_gnt) begin
      sram_en    = 1'b1;
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (inst_gnt) begin
      sram_en    = 1'b1;
      sram_addr  = inst_addr;
    end
  end

  // Owner tags for the response due next cycle (grants are already 0 in reset).
  always_comb begin
    resp_inst_d = inst_gnt;
    resp_data_d = data_gnt;
  end

  // Owner tag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_inst_q <= 1'b0;
      resp_data_q <= 1'b0;
    end else begin
      resp_inst_q <= resp_inst_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Return path: cancel only masks the fetch response; reset blanks everything.
  always_comb begin
    inst_rvalid = resp_inst_q & ~inst_cancel & ~rst;
    data_rvalid = resp_data_q & ~rst;
    inst_rdata  = rst ? '0 : sram_rdata;
    data_rdata  = rst ? '0 : sram_rdata;
  end

  logic unused_starve_cnt;
  assign unused_starve_cnt = ^starve_cnt;

endmodule
